qam_cfg_sequencer: RTL and testbench

- Run-time configuration controller for the QAM modulator datapath.
- Accepts configuration requests (modulation, baud, filter mode, carrier frequency) over a valid/ready handshake.
- Applies each change safely: mute the output, flush the datapath by holding its reset, apply the new settings, wait for the shaping filter and CIC to settle, then unmute.
- Sits between the host/register interface and the modulator top; drives the datapath reset and all config inputs, and gates the 32-bit mod_iq output.

---
 rtl/qam_pkg.sv | 35 +++
 rtl/qam_settle_calc.sv | 22 ++
 rtl/qam_cfg_sequencer.sv | 150 +++++++++++++++
 tb/tb_qam_cfg_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM configuration sequencer.
package qam_pkg;

  // Clock cycles per symbol at the fastest baud (11059200 / 19200).
  localparam int unsigned CLK_PER_SYM_MIN = 576;

  // Width of the shared state-duration counter.
  localparam int unsigned CNT_W = 20;

  // Baud codes; the slowest rate uses the longest symbol.
  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_e;

  // Packed configuration word, MSB first.
  typedef struct packed {
    logic        mod_type;
    logic [1:0]  baud_rate;
    logic        filter_enable;
    logic        use_sqrt_rcos;
    logic [15:0] carrier_freq;
  } cfg_t;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_SETTLE,
    ST_RUN,
    ST_MUTE,
    ST_APPLY
  } state_e;

endpackage

// File: rtl/qam_settle_calc.sv
// Settle duration in clk cycles for a given baud code: symbols times
// the symbol period, which doubles for each step below 19200 Bd.
module qam_settle_calc
  import qam_pkg::*;
#(
  parameter int unsigned SETTLE_SYMBOLS = 16
) (
  input  logic [1:0]       baud_rate_i,
  output logic [CNT_W-1:0] settle_cycles_o
);

  logic [1:0]       shift_amt;
  logic [CNT_W-1:0] clk_per_sym;

  // Shift the minimum symbol period up for slower bauds, then scale.
  always_comb begin
    shift_amt       = 2'(BAUD_19200) - baud_rate_i;
    clk_per_sym     = CNT_W'(CLK_PER_SYM_MIN) << shift_amt;
    settle_cycles_o = clk_per_sym * CNT_W'(SETTLE_SYMBOLS);
  end

endmodule

// File: rtl/qam_cfg_sequencer.sv
// Run-time configuration sequencer for the QAM modulator: accepts a
// request, mutes the output, flushes the datapath under reset, applies
// the new settings, waits for the filters to settle, then unmutes.
module qam_cfg_sequencer
  import qam_pkg::*;
#(
  parameter int unsigned MUTE_CYCLES    = 64,
  parameter int unsigned FLUSH_CYCLES   = 16,
  parameter int unsigned SETTLE_SYMBOLS = 16,
  parameter logic [20:0] DEF_CFG        = 21'h0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_mod_type,
  input  logic [1:0]  cfg_baud_rate,
  input  logic        cfg_filter_enable,
  input  logic        cfg_use_sqrt_rcos,
  input  logic [15:0] cfg_carrier_freq,
  output logic        mod_type,
  output logic [1:0]  baud_rate,
  output logic        filter_enable,
  output logic        use_sqrt_rcos,
  output logic [15:0] carrier_freq_set,
  output logic        dp_rst_n,
  input  logic [31:0] mod_iq_in,
  output logic [31:0] mod_iq,
  output logic        busy,
  output logic        cfg_done
);

  localparam logic [CNT_W-1:0] MUTE_LAST  = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  cfg_t             applied_q, applied_d;
  cfg_t             pending_q, pending_d;
  logic             done_q, done_d;
  logic [31:0]      mod_iq_q;

  cfg_t             req;
  logic             handshake;
  logic [CNT_W-1:0] settle_cycles;
  logic [CNT_W-1:0] settle_last;

  assign req = {cfg_mod_type, cfg_baud_rate, cfg_filter_enable,
                cfg_use_sqrt_rcos, cfg_carrier_freq};

  // Settle time follows the applied baud, which is already updated by SETTLE.
  qam_settle_calc #(
    .SETTLE_SYMBOLS (SETTLE_SYMBOLS)
  ) u_settle_calc (
    .baud_rate_i     (applied_q.baud_rate),
    .settle_cycles_o (settle_cycles)
  );

  assign settle_last = settle_cycles - CNT_W'(1);

  // Status outputs decode the state and are forced to reset values by rst.
  assign cfg_ready = !rst && (state_q == ST_RUN);
  assign busy      = rst || (state_q != ST_RUN);
  assign dp_rst_n  = !rst && (state_q == ST_SETTLE || state_q == ST_RUN ||
                              state_q == ST_MUTE);
  assign handshake = cfg_valid && cfg_ready;

  assign mod_type         = applied_q.mod_type;
  assign baud_rate        = applied_q.baud_rate;
  assign filter_enable    = applied_q.filter_enable;
  assign use_sqrt_rcos    = applied_q.use_sqrt_rcos;
  assign carrier_freq_set = applied_q.carrier_freq;
  assign mod_iq           = mod_iq_q;
  assign cfg_done         = done_q;

  // Next-state, counter and config-register update logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    first_d   = first_q;
    applied_d = applied_q;
    pending_d = pending_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          if (first_q) begin
            state_d = ST_SETTLE;
            first_d = 1'b0;
          end else begin
            // Load on entry to APPLY so the change is visible only while
            // the datapath is still held in reset.
            state_d   = ST_APPLY;
            applied_d = pending_q;
          end
        end
      end
      ST_APPLY: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt_q == settle_last) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          if (req == applied_q) begin
            done_d = 1'b1;
          end else begin
            pending_d = req;
            state_d   = ST_MUTE;
          end
        end
      end
      ST_MUTE: begin
        if (cnt_q == MUTE_LAST) state_d = ST_FLUSH;
      end
      default: state_d = ST_FLUSH;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= ST_FLUSH;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      applied_q <= cfg_t'(DEF_CFG);
      pending_q <= cfg_t'(DEF_CFG);
      done_q    <= 1'b0;
      mod_iq_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      applied_q <= applied_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      mod_iq_q  <= (state_q == ST_RUN) ? mod_iq_in : 32'h0;
    end
  end

endmodule

// File: tb/tb_qam_cfg_sequencer.sv
// Directed bench for qam_cfg_sequencer with SETTLE_SYMBOLS=1, plus a
// table check of qam_settle_calc at SETTLE_SYMBOLS=16.
module tb_qam_cfg_sequencer;
  import qam_pkg::*;

  localparam int FLUSH_N = 16;
  localparam int MUTE_N  = 64;
  localparam int BOUND   = 10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_mod_type = 1'b0;
  logic [1:0]  cfg_baud_rate = 2'b00;
  logic        cfg_filter_enable = 1'b0;
  logic        cfg_use_sqrt_rcos = 1'b0;
  logic [15:0] cfg_carrier_freq = 16'h0;
  logic        mod_type;
  logic [1:0]  baud_rate;
  logic        filter_enable;
  logic        use_sqrt_rcos;
  logic [15:0] carrier_freq_set;
  logic        dp_rst_n;
  logic [31:0] mod_iq_in = 32'hC0DE_0001;
  logic [31:0] mod_iq;
  logic        busy;
  logic        cfg_done;

  logic [1:0]  calc_baud = 2'b00;
  logic [19:0] calc_cycles;

  cfg_t applied;
  cfg_t model_cfg;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic [1:0] baud;
    int         exp_cycles;
  } calc_vec_t;

  typedef struct {
    cfg_t req;
    int   exp_settle;
  } sweep_vec_t;

  calc_vec_t  calc_vec[4];
  sweep_vec_t sweep_vec[4];

  always #5 clk = ~clk;

  qam_cfg_sequencer #(
    .MUTE_CYCLES    (MUTE_N),
    .FLUSH_CYCLES   (FLUSH_N),
    .SETTLE_SYMBOLS (1),
    .DEF_CFG        (21'h0)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_mod_type      (cfg_mod_type),
    .cfg_baud_rate     (cfg_baud_rate),
    .cfg_filter_enable (cfg_filter_enable),
    .cfg_use_sqrt_rcos (cfg_use_sqrt_rcos),
    .cfg_carrier_freq  (cfg_carrier_freq),
    .mod_type          (mod_type),
    .baud_rate         (baud_rate),
    .filter_enable     (filter_enable),
    .use_sqrt_rcos     (use_sqrt_rcos),
    .carrier_freq_set  (carrier_freq_set),
    .dp_rst_n          (dp_rst_n),
    .mod_iq_in         (mod_iq_in),
    .mod_iq            (mod_iq),
    .busy              (busy),
    .cfg_done          (cfg_done)
  );

  qam_settle_calc #(
    .SETTLE_SYMBOLS (16)
  ) u_calc16 (
    .baud_rate_i     (calc_baud),
    .settle_cycles_o (calc_cycles)
  );

  assign applied = {mod_type, baud_rate, filter_enable, use_sqrt_rcos, carrier_freq_set};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  function automatic cfg_t mk(input logic m, input logic [1:0] b, input logic f,
                              input logic s, input logic [15:0] c);
    cfg_t r;
    r.mod_type      = m;
    r.baud_rate     = b;
    r.filter_enable = f;
    r.use_sqrt_rcos = s;
    r.carrier_freq  = c;
    return r;
  endfunction

  task automatic drive_req(input cfg_t r);
    {cfg_mod_type, cfg_baud_rate, cfg_filter_enable, cfg_use_sqrt_rcos, cfg_carrier_freq} = r;
  endtask

  // Count consecutive busy cycles at a given dp_rst_n level, sampled at negedge.
  task automatic phase(input logic lvl, input cfg_t watch, output int n,
                       output int n_match, output int n_done, output int n_iq);
    n = 0; n_match = 0; n_done = 0; n_iq = 0;
    while (busy === 1'b1 && dp_rst_n === lvl && n < BOUND) begin
      n++;
      if (applied === watch) n_match++;
      if (cfg_done !== 1'b0) n_done++;
      if (mod_iq !== 32'h0) n_iq++;
      @(negedge clk);
    end
  endtask

  // Full power-up sequence after rst has just been released (DEF_CFG = 0).
  task automatic after_reset(input string tag);
    int n, m, d, q;
    phase(1'b0, cfg_t'(21'h0), n, m, d, q);
    check({tag, "_flush_len"}, n, FLUSH_N);
    check({tag, "_flush_cfg_def"}, m, FLUSH_N);
    phase(1'b1, cfg_t'(21'h0), n, m, d, q);
    check({tag, "_settle_len"}, n, 4608);
    check({tag, "_settle_cfg_def"}, m, 4608);
    check({tag, "_settle_no_done"}, d, 0);
    check({tag, "_settle_iq_muted"}, q, 0);
    check({tag, "_run_busy"}, busy, 0);
    check({tag, "_run_done"}, cfg_done, 1);
    check({tag, "_run_ready"}, cfg_ready, 1);
    check({tag, "_run_iq_first"}, mod_iq, 0);
    mod_iq_in = 32'h1234_5678;
    @(negedge clk);
    check({tag, "_iq_track"}, mod_iq, 32'h1234_5678);
    check({tag, "_done_once"}, cfg_done, 0);
    mod_iq_in = 32'hC0DE_0001;
    model_cfg = cfg_t'(21'h0);
  endtask

  // Sequence after a changing request was accepted at the current negedge.
  task automatic follow_change(input cfg_t req, input int exp_settle, input string tag);
    int n, m, d, q;
    @(negedge clk);
    cfg_valid = 1'b0;
    check({tag, "_busy_a1"}, busy, 1);
    @(negedge clk);
    check({tag, "_iq_muted"}, mod_iq, 0);
    phase(1'b1, model_cfg, n, m, d, q);
    check({tag, "_mute_len"}, n, MUTE_N - 1);
    check({tag, "_mute_cfg_old"}, m, MUTE_N - 1);
    check({tag, "_mute_iq"}, q, 0);
    phase(1'b0, req, n, m, d, q);
    check({tag, "_dprst_len"}, n, FLUSH_N + 1);
    check({tag, "_apply_only"}, m, 1);
    check({tag, "_flush_iq"}, q, 0);
    phase(1'b1, req, n, m, d, q);
    check({tag, "_settle_len"}, n, exp_settle);
    check({tag, "_settle_cfg"}, m, exp_settle);
    check({tag, "_settle_no_done"}, d, 0);
    check({tag, "_run_done"}, cfg_done, 1);
    check({tag, "_run_cfg"}, applied, req);
    model_cfg = req;
    @(negedge clk);
    check({tag, "_done_once"}, cfg_done, 0);
  endtask

  task automatic do_change(input cfg_t req, input int exp_settle, input string tag);
    drive_req(req);
    cfg_valid = 1'b1;
    #1;
    check({tag, "_ready"}, cfg_ready, 1);
    follow_change(req, exp_settle, tag);
  endtask

  initial begin
    int n, bad;
    cfg_t r2, r3, r4;

    calc_vec[0] = '{2'b00, 73728};
    calc_vec[1] = '{2'b01, 36864};
    calc_vec[2] = '{2'b10, 18432};
    calc_vec[3] = '{2'b11, 9216};
    sweep_vec[0] = '{mk(1'b0, 2'b01, 1'b1, 1'b0, 16'd2000), 2304};
    sweep_vec[1] = '{mk(1'b1, 2'b10, 1'b0, 1'b1, 16'd3000), 1152};
    sweep_vec[2] = '{mk(1'b0, 2'b11, 1'b1, 1'b1, 16'd4000), 576};
    sweep_vec[3] = '{mk(1'b1, 2'b00, 1'b0, 1'b0, 16'd5000), 4608};
    model_cfg = cfg_t'(21'h0);

    // Settle calculator at 16 symbols for every baud code.
    for (int i = 0; i < 4; i++) begin
      calc_baud = calc_vec[i].baud;
      #1;
      check($sformatf("calc16_baud%0d", i), calc_cycles, calc_vec[i].exp_cycles);
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dp_rst_n", dp_rst_n, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", cfg_ready, 0);
    check("rst_done", cfg_done, 0);
    check("rst_iq", mod_iq, 0);
    check("rst_cfg", applied, 0);
    rst = 1'b0;
    #1;
    after_reset("por");

    // Change to 16QAM / 19200 / filter on / sqrt-rcos / 10 kHz.
    do_change(mk(1'b1, 2'b11, 1'b1, 1'b1, 16'd10000), 576, "chg1");

    // Identical request: no mute, done pulse at accept+1.
    drive_req(model_cfg);
    cfg_valid = 1'b1;
    #1;
    check("same_ready", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("same_done", cfg_done, 1);
    check("same_busy", busy, 0);
    check("same_dp", dp_rst_n, 1);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || dp_rst_n !== 1'b1 || cfg_done !== 1'b0) bad++;
    end
    check("same_quiet", bad, 0);

    // Held cfg_valid with changing fields during a sequence.
    r2 = mk(1'b0, 2'b01, 1'b0, 1'b1, 16'd1234);
    r3 = mk(1'b1, 2'b10, 1'b0, 1'b0, 16'd5555);
    drive_req(r2);
    cfg_valid = 1'b1;
    #1;
    check("hold_ready0", cfg_ready, 1);
    @(negedge clk);
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < BOUND) begin
      cfg_mod_type      = 1'($urandom);
      cfg_baud_rate     = 2'($urandom);
      cfg_filter_enable = 1'($urandom);
      cfg_use_sqrt_rcos = 1'($urandom);
      cfg_carrier_freq  = 16'($urandom);
      #1;
      if (cfg_ready !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    check("hold_busy_len", n, MUTE_N + FLUSH_N + 1 + 2304);
    check("hold_no_ready", bad, 0);
    check("hold_cfg_r2", applied, r2);
    check("hold_done", cfg_done, 1);
    model_cfg = r2;
    drive_req(r3);
    #1;
    check("hold_ready1", cfg_ready, 1);
    follow_change(r3, 1152, "hold_r3");

    // Reset mid-SETTLE after switching to 19200: pending request is lost.
    r4 = mk(1'b0, 2'b11, 1'b1, 1'b0, 16'd777);
    drive_req(r4);
    cfg_valid = 1'b1;
    #1;
    check("midrst_ready", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (MUTE_N + FLUSH_N + 100) @(negedge clk);
    check("midrst_in_settle", {busy, dp_rst_n}, 2'b11);
    check("midrst_cfg_r4", applied, r4);
    rst = 1'b1;
    #1;
    check("midrst_dp", dp_rst_n, 0);
    check("midrst_busy", busy, 1);
    check("midrst_ready_lo", cfg_ready, 0);
    repeat (2) @(negedge clk);
    check("midrst_cfg_def", applied, 0);
    check("midrst_iq", mod_iq, 0);
    rst = 1'b0;
    #1;
    after_reset("rerun");

    // Baud sweep on the sequencer (1 settle symbol).
    for (int i = 0; i < 4; i++) begin
      do_change(sweep_vec[i].req, sweep_vec[i].exp_settle, $sformatf("sweep%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
